dmem_arbiter: RTL

//  Shares the single-port data memory between two requesters: port 0 is the ARM

---
 rtl/dmem_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares a single-port data memory (combinational read, synchronous write)
// between two masters:
//   port 0 : the core's load/store path (stalled while it waits)
//   port 1 : a secondary master (loader / DMA / debug)
//
// Arbitration is round-robin with a bounded burst: an owner may take at most
// MAX_BURST consecutive acks while the other port is requesting. With the
// other port idle, the owner streams indefinitely. A request raised while the
// arbiter is idle is acked on the following cycle. After that, an owner that
// keeps its request high is acked every cycle.
//
// Ports
//   clk_i        system clock, all state on the rising edge
//   rst_i        asynchronous, active-high reset
//   m0_req_i     core request (held with we/addr/wdata until acked)
//   m0_we_i      1 = write, 0 = read
//   m0_addr_i    byte address
//   m0_wdata_i   write data
//   m0_ack_o     access performed this cycle; rdata valid this cycle
//   m0_rdata_o   read data (always mem_rd_i)
//   m1_*         same set for the secondary master
//   cpu_stall_o  core is requesting but not acked this cycle
//   owner_o      00 idle, 01 port 0, 10 port 1 (registered state)
//   mem_we_o     data memory write enable
//   mem_a_o      data memory address
//   mem_wd_o     data memory write data
//   mem_rd_i     data memory combinational read data
// ----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_wdata_i,
    output logic          m0_ack_o,
    output logic [DW-1:0] m0_rdata_o,

    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_wdata_i,
    output logic          m1_ack_o,
    output logic [DW-1:0] m1_rdata_o,

    output logic          cpu_stall_o,
    output logic [1:0]    owner_o,

    output logic          mem_we_o,
    output logic [AW-1:0] mem_a_o,
    output logic [DW-1:0] mem_wd_o,
    input  logic [DW-1:0] mem_rd_i
);

    // A one-deep burst still needs a 1-bit counter to keep the logic legal.
    localparam int unsigned    CntW   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST - 1);

    // Encoding matches the owner_o code so the state drives it directly.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StOwn0 = 2'b01,
        StOwn1 = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic            last_q,  last_d;   // 1: port 1 was served most recently
    logic [CntW-1:0] cnt_q,   cnt_d;    // acks in the current tenure, saturating

    // Requests seen from the point of view of the current owner.
    logic   req_cur;
    logic   req_oth;
    state_e st_oth;

    always_comb begin
        req_cur = 1'b0;
        req_oth = 1'b0;
        st_oth  = StIdle;
        unique case (state_q)
            StOwn0: begin
                req_cur = m0_req_i;
                req_oth = m1_req_i;
                st_oth  = StOwn1;
            end
            StOwn1: begin
                req_cur = m1_req_i;
                req_oth = m0_req_i;
                st_oth  = StOwn0;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (m0_req_i && m1_req_i) begin
                    // Tie goes to the port that was not served last.
                    state_d = last_q ? StOwn0 : StOwn1;
                end else if (m0_req_i) begin
                    state_d = StOwn0;
                end else if (m1_req_i) begin
                    state_d = StOwn1;
                end
            end

            StOwn0, StOwn1: begin
                // Track the owner every cycle so IDLE remembers who went last.
                last_d = (state_q == StOwn1);
                if (!req_cur) begin
                    state_d = req_oth ? st_oth : StIdle;
                    cnt_d   = '0;
                end else if (req_oth && (cnt_q == CntMax)) begin
                    // This cycle's ack is the last of the burst.
                    state_d = st_oth;
                    cnt_d   = '0;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            last_q  <= 1'b1;   // port 0 wins the first tie
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath: purely a function of the registered owner, so an asynchronous
    // reset drops acks and the write enable without waiting for a clock.
    // ------------------------------------------------------------------------
    always_comb begin
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        mem_we_o = 1'b0;
        mem_a_o  = '0;
        mem_wd_o = '0;

        unique case (state_q)
            StOwn0: begin
                m0_ack_o = m0_req_i;
                mem_we_o = m0_req_i & m0_we_i;
                mem_a_o  = m0_addr_i;
                mem_wd_o = m0_wdata_i;
            end
            StOwn1: begin
                m1_ack_o = m1_req_i;
                mem_we_o = m1_req_i & m1_we_i;
                mem_a_o  = m1_addr_i;
                mem_wd_o = m1_wdata_i;
            end
            default: ;
        endcase
    end

    assign m0_rdata_o  = mem_rd_i;
    assign m1_rdata_o  = mem_rd_i;
    assign cpu_stall_o = m0_req_i & ~m0_ack_o;
    assign owner_o     = state_q;

endmodule
